// File: rtl/upperimm_dispatch_ctrl.sv
// U-type (LUI/AUIPC) decode and two-entry skid dispatch buffer with flush and illegal-opcode pulse.
// Optional dispatch counter enabled by defining UPPERIMM_PERF_CNT_EN.
`ifndef ALU_NOP
`define ALU_NOP 5'd0
`endif
`ifndef LUI
`define LUI 5'd14
`endif
`ifndef AUIPC
`define AUIPC 5'd15
`endif

module upperimm_dispatch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [4:0]  out_alu_control,
    output logic [31:0] out_result,
    output logic        err_illegal,
    output logic [15:0] perf_upperimm_cnt,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [31:0] res;
    } op_t;

    localparam op_t OP_NONE = '{rd: 5'd0, imm: 32'd0, alu: `ALU_NOP, res: 32'd0};

    state_t state_q, state_d;
    op_t    out_q, out_d;
    op_t    skid_q, skid_d;
    logic   out_valid_q;
    logic   in_ready_q;
    logic   err_q, err_d;

    logic [6:0]  opcode;
    logic        is_lui, is_auipc, is_upper;
    logic [31:0] imm;
    op_t         dec;
    logic        accept, push, pop;

    assign opcode   = in_instr[6:0];
    assign is_lui   = (opcode == 7'd55);
    assign is_auipc = (opcode == 7'd23);
    assign is_upper = is_lui || is_auipc;
    assign imm      = {in_instr[31:12], 12'b0};

    always_comb begin
        dec.rd  = in_instr[11:7];
        dec.imm = imm;
        dec.alu = is_lui ? `LUI : `AUIPC;
        dec.res = is_lui ? imm : (in_pc + imm);
    end

    // An accepted op that is flushed in the same cycle is dropped silently.
    assign accept = in_valid && in_ready_q;
    assign push   = accept && is_upper && !flush;
    assign pop    = out_valid_q && out_ready;
    assign err_d  = accept && !is_upper && !flush;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            out_d   = OP_NONE;
            skid_d  = OP_NONE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        out_d   = dec;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_d = dec;
                    end else if (push) begin
                        state_d = TWO;
                        skid_d  = dec;
                    end else if (pop) begin
                        state_d = EMPTY;
                        out_d   = OP_NONE;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        out_d   = skid_q;
                        skid_d  = OP_NONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    out_d   = OP_NONE;
                    skid_d  = OP_NONE;
                end
            endcase
        end
    end

    // Handshake flags are registered from the next state so neither depends on inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_q       <= OP_NONE;
            skid_q      <= OP_NONE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != TWO);
            err_q       <= err_d;
        end
    end

`ifdef UPPERIMM_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else if (pop && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign perf_upperimm_cnt = cnt_q;
`else
    assign perf_upperimm_cnt = 16'h0000;
`endif

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_rd          = out_q.rd;
    assign out_imm         = out_q.imm;
    assign out_alu_control = out_q.alu;
    assign out_result      = out_q.res;
    assign err_illegal     = err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_upperimm_dispatch_ctrl.sv
// Bench for upperimm_dispatch_ctrl: queue-based reference model checked every cycle plus directed literal checks.
`ifndef ALU_NOP
`define ALU_NOP 5'd0
`endif
`ifndef LUI
`define LUI 5'd14
`endif
`ifndef AUIPC
`define AUIPC 5'd15
`endif

module tb_upperimm_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, err_illegal;
    logic [4:0]  out_rd, out_alu_control;
    logic [31:0] out_imm, out_result;
    logic [15:0] perf_upperimm_cnt;
    logic [1:0]  dbg_state_o;

    int vec_cnt  = 0;
    int fail_cnt = 0;

    upperimm_dispatch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_pc             (in_pc),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_rd            (out_rd),
        .out_imm           (out_imm),
        .out_alu_control   (out_alu_control),
        .out_result        (out_result),
        .err_illegal       (err_illegal),
        .perf_upperimm_cnt (perf_upperimm_cnt),
        .dbg_state_o       (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [31:0] res;
    } m_op_t;

    m_op_t       exp_q[$];
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    function automatic m_op_t model_decode(input logic [31:0] instr, input logic [31:0] pc);
        m_op_t o;
        o.rd  = instr[11:7];
        o.imm = {instr[31:12], 12'h000};
        if (instr[6:0] == 7'h37) begin
            o.alu = `LUI;
            o.res = o.imm;
        end else begin
            o.alu = `AUIPC;
            o.res = pc + o.imm;
        end
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_err = 1'b0;
            m_cnt = 16'h0000;
        end else begin
            int  sz;
            bit  acc, pp, legal;
            sz    = exp_q.size();
            acc   = in_valid && (sz < 2);
            pp    = (sz > 0) && out_ready;
            legal = (in_instr[6:0] == 7'h37) || (in_instr[6:0] == 7'h17);
            if (pp) begin
                void'(exp_q.pop_front());
`ifdef UPPERIMM_PERF_CNT_EN
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end
            if (flush) begin
                exp_q.delete();
                m_err = 1'b0;
            end else begin
                if (acc && legal) exp_q.push_back(model_decode(in_instr, in_pc));
                m_err = acc && !legal;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        m_op_t f;
        int    sz;
        sz = exp_q.size();
        if (sz > 0) f = exp_q[0];
        else f = '{rd: 5'd0, imm: 32'd0, alu: `ALU_NOP, res: 32'd0};
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
        chk("m_in_ready",  {31'd0, in_ready},  {31'd0, sz < 2});
        chk("m_out_rd",    {27'd0, out_rd},    {27'd0, f.rd});
        chk("m_out_imm",   out_imm,            f.imm);
        chk("m_out_alu",   {27'd0, out_alu_control}, {27'd0, f.alu});
        chk("m_out_result", out_result,        f.res);
        chk("m_err",       {31'd0, err_illegal}, {31'd0, m_err});
        chk("m_perf_cnt",  {16'd0, perf_upperimm_cnt}, {16'd0, m_cnt});
        chk("m_state",     {30'd0, dbg_state_o}, sz);
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [19:0] u, input logic [4:0] rd, input logic [6:0] opc);
        return {u, rd, opc};
    endfunction

    initial begin
        in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu",       {27'd0, out_alu_control}, {27'd0, `ALU_NOP});
        chk("rst_cnt",       {16'd0, perf_upperimm_cnt}, 32'd0);

        // First acceptance right after reset release: LUI
        rst = 1'b0;
        in_valid = 1'b1; in_instr = 32'h123450B7;
        tick();
        chk("lui_valid",  {31'd0, out_valid}, 32'd1);
        chk("lui_rd",     {27'd0, out_rd}, 32'd1);
        chk("lui_imm",    out_imm, 32'h12345000);
        chk("lui_alu",    {27'd0, out_alu_control}, {27'd0, `LUI});
        chk("lui_result", out_result, 32'h12345000);

        in_instr = 32'h00001117; in_pc = 32'h100;
        tick();
        chk("auipc_rd",     {27'd0, out_rd}, 32'd2);
        chk("auipc_imm",    out_imm, 32'h00001000);
        chk("auipc_result", out_result, 32'h00001100);
        chk("auipc_alu",    {27'd0, out_alu_control}, {27'd0, `AUIPC});

        in_valid = 1'b0;
        tick();
        chk("drain_valid",  {31'd0, out_valid}, 32'd0);
        chk("drain_result", out_result, 32'd0);

        // Backpressure: three LUIs with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(20'hAAAAA, 5'd3, 7'h37);
        tick();
        chk("bp1_ready", {31'd0, in_ready}, 32'd1);
        chk("bp1_rd",    {27'd0, out_rd}, 32'd3);
        in_instr = mk(20'hBBBBB, 5'd4, 7'h37);
        tick();
        chk("bp2_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2_rd",    {27'd0, out_rd}, 32'd3);
        in_instr = mk(20'hCCCCC, 5'd5, 7'h37);
        tick();
        chk("bp3_ready", {31'd0, in_ready}, 32'd0);
        chk("bp3_rd",    {27'd0, out_rd}, 32'd3);
        chk("bp3_imm",   out_imm, 32'hAAAAA000);
        out_ready = 1'b1;
        tick();
        chk("bp4_rd",    {27'd0, out_rd}, 32'd4);
        chk("bp4_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp5_rd",    {27'd0, out_rd}, 32'd5);
        chk("bp5_imm",   out_imm, 32'hCCCCC000);
        in_valid = 1'b0;
        tick();
        chk("bp6_valid", {31'd0, out_valid}, 32'd0);

        // Illegal opcode while EMPTY
        in_valid = 1'b1; in_instr = 32'h00000033;
        tick();
        chk("ill_err",   {31'd0, err_illegal}, 32'd1);
        chk("ill_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        tick();
        chk("ill_err_off", {31'd0, err_illegal}, 32'd0);

        // Illegal opcode while ONE leaves the buffer untouched
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(20'h11111, 5'd6, 7'h37);
        tick();
        in_instr = 32'h00000033;
        tick();
        chk("ill1_err",   {31'd0, err_illegal}, 32'd1);
        chk("ill1_rd",    {27'd0, out_rd}, 32'd6);
        chk("ill1_ready", {31'd0, in_ready}, 32'd1);

        // Fill to TWO, then flush with an incoming op
        in_instr = mk(20'h22222, 5'd7, 7'h37);
        tick();
        chk("two_ready", {31'd0, in_ready}, 32'd0);
        in_instr = mk(20'h33333, 5'd8, 7'h37); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_never", {31'd0, out_valid}, 32'd0);

        // Illegal op accepted in the flush cycle raises nothing
        in_valid = 1'b1; in_instr = 32'h00000033; flush = 1'b1;
        tick();
        chk("fl_ill_err", {31'd0, err_illegal}, 32'd0);
        flush = 1'b0;

        // Pop coinciding with flush
        in_instr = mk(20'h44444, 5'd9, 7'h37);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flpop_valid", {31'd0, out_valid}, 32'd0);

        // AUIPC wrap-around
        in_valid = 1'b1; in_instr = 32'hFFFFF017; in_pc = 32'h2000;
        tick();
        chk("wrap_result", out_result, 32'h00001000);
        chk("wrap_imm",    out_imm, 32'hFFFFF000);
        chk("wrap_rd",     {27'd0, out_rd}, 32'd0);
        in_valid = 1'b0;
        tick();

        // Reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(20'h55555, 5'd10, 7'h37);
        tick();
        in_instr = mk(20'h66666, 5'd11, 7'h17);
        tick();
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_rd",    {27'd0, out_rd}, 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_instr = mk(20'h77777, 5'd12, 7'h37);
        tick();
        chk("post_rst_rd", {27'd0, out_rd}, 32'd12);
        chk("post_rst_err", {31'd0, err_illegal}, 32'd0);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 9) == 0);
            in_pc     = $urandom;
            case ($urandom_range(0, 3))
                0: in_instr = mk(20'($urandom), 5'($urandom), 7'h37);
                1: in_instr = mk(20'($urandom), 5'($urandom), 7'h17);
                2: in_instr = mk(20'($urandom), 5'($urandom), 7'h13);
                default: in_instr = mk(20'($urandom), 5'($urandom), 7'h17);
            endcase
            tick();
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
